mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8x8 iterative shift-add multiplier among `N` requesters. It accepts one operand pair at a time, issues a single-cycle `start` to the multiplier, waits for the multiplier's `ready`, and returns the 16-bit product to the requester that was granted. A watchdog recovers the arbiter if the multiplier never reports completion. The block sits between client blocks and the shared multiplier instance; the multiplier itself is external.

---
 rtl/mul_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mul_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 8x8 iterative multiplier
// among N requesters, with a watchdog that converts a stuck multiplier into an error response.
module mul_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_a,
  input  logic [8*N-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           resp_valid,
  output logic [2:0]     resp_id,
  output logic [15:0]    resp_product,
  output logic           resp_err,
  output logic           mul_start,
  output logic [7:0]     mul_a,
  output logic [7:0]     mul_b,
  input  logic [15:0]    mul_product,
  input  logic           mul_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int             WDW      = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  logic [1:0]     state_r;
  logic [2:0]     ptr_r;
  logic [WDW-1:0] wdog_r;
  logic           resp_valid_r;
  logic [2:0]     resp_id_r;
  logic [15:0]    resp_product_r;
  logic           resp_err_r;
  logic           mul_start_r;
  logic [7:0]     mul_a_r;
  logic [7:0]     mul_b_r;

  logic [7:0]     valid_pad_s;
  logic [63:0]    a_pad_s;
  logic [63:0]    b_pad_s;
  logic [3:0]     cand_s;
  logic           win_found_s;
  logic [2:0]     win_idx_s;
  logic [2:0]     ptr_nxt_s;
  logic [7:0]     ready_pad_s;

  // Widen request vectors to the 8-requester maximum so every index is full width.
  always_comb begin
    valid_pad_s          = 8'd0;
    valid_pad_s[N-1:0]   = req_valid;
    a_pad_s              = 64'd0;
    a_pad_s[8*N-1:0]     = req_a;
    b_pad_s              = 64'd0;
    b_pad_s[8*N-1:0]     = req_b;
  end

  // Round-robin search: first valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    cand_s      = 4'd0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_r} + 4'(k);
      if (cand_s >= 4'(N)) begin
        cand_s = cand_s - 4'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && valid_pad_s[cand_s[2:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[2:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pointer moves to the slot just after the winner.
  always_comb begin
    if (win_idx_s == 3'(N - 1)) begin
      ptr_nxt_s = 3'd0;
    end else begin
      ptr_nxt_s = win_idx_s + 3'd1;
    end
  end

  // One-hot accept, only in IDLE; forced low while reset is asserted.
  always_comb begin
    ready_pad_s = 8'd0;
    if (rst_n && (state_r == ST_IDLE) && win_found_s) begin
      ready_pad_s[win_idx_s] = 1'b1;
    end else begin
      ready_pad_s = 8'd0;
    end
    req_ready = ready_pad_s[N-1:0];
  end

  // Sequencer: grant, start pulse, watchdog-bounded wait, one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      ptr_r          <= 3'd0;
      wdog_r         <= '0;
      resp_valid_r   <= 1'b0;
      resp_id_r      <= 3'd0;
      resp_product_r <= 16'd0;
      resp_err_r     <= 1'b0;
      mul_start_r    <= 1'b0;
      mul_a_r        <= 8'd0;
      mul_b_r        <= 8'd0;
    end else begin
      mul_start_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            mul_a_r     <= a_pad_s[{win_idx_s, 3'b000} +: 8];
            mul_b_r     <= b_pad_s[{win_idx_s, 3'b000} +: 8];
            resp_id_r   <= win_idx_s;
            ptr_r       <= ptr_nxt_s;
            mul_start_r <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wdog_r  <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wdog_r != WD_LIMIT) begin
            wdog_r <= wdog_r + WDW'(1);
          end else begin
            wdog_r <= wdog_r;
          end
          // Completion wins over the watchdog when both occur in the same cycle.
          if (mul_ready) begin
            resp_product_r <= mul_product;
            resp_err_r     <= 1'b0;
            resp_valid_r   <= 1'b1;
            state_r        <= ST_RESP;
          end else if (wdog_r >= WD_LIMIT) begin
            resp_product_r <= 16'd0;
            resp_err_r     <= 1'b1;
            resp_valid_r   <= 1'b1;
            state_r        <= ST_RESP;
          end else begin
            state_r        <= ST_WAIT;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid   = resp_valid_r;
  assign resp_id      = resp_id_r;
  assign resp_product = resp_product_r;
  assign resp_err     = resp_err_r;
  assign mul_start    = mul_start_r;
  assign mul_a        = mul_a_r;
  assign mul_b        = mul_b_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: behavioural 8-cycle multiplier plus a
// high-level round-robin reference, exercised through scenario tasks.
module tb_mul_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [2:0]     resp_id;
  logic [15:0]    resp_product;
  logic           resp_err;
  logic           mul_start;
  logic [7:0]     mul_a;
  logic [7:0]     mul_b;
  logic [15:0]    mul_product = 16'd0;
  logic           mul_ready = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   exp_ptr = 0;
  int   lat = 8;
  bit   hold_ready = 1'b0;
  int   mcnt = 0;
  logic [7:0] opa [N];
  logic [7:0] opb [N];

  mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_product(resp_product), .resp_err(resp_err), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .mul_ready(mul_ready)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: ready drops after start, rises lat cycles later (never if hold_ready).
  always @(posedge clk) begin
    if (mul_start) begin
      mcnt        <= lat;
      mul_ready   <= 1'b0;
      mul_product <= {8'd0, mul_a} * {8'd0, mul_b};
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !hold_ready) mul_ready <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish got=running exp=finished");
    $fatal(1);
  end

  function automatic int ref_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = opa[i];
      req_b[8*i +: 8] = opb[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = 8'($urandom);
      opb[i] = 8'($urandom);
    end
    pack_ops();
  endtask

  task automatic test_reset();
    rand_ops();
    req_valid = '1;
    rst_n = 1'b0;
    step();
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset req_ready got=%b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_id !== 3'd0) begin errors++; $display("FAIL reset resp_id got=%0d exp=0", resp_id); end
    checks++; if (resp_product !== 16'd0) begin errors++; $display("FAIL reset resp_product got=%h exp=0", resp_product); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err got=%b exp=0", resp_err); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset mul_start got=%b exp=0", mul_start); end
    checks++; if ({mul_a, mul_b} !== 16'd0) begin errors++; $display("FAIL reset mul_ab got=%h exp=0", {mul_a, mul_b}); end
    req_valid = '0;
    step();
    rst_n = 1'b1;
    exp_ptr = 0;
    step();
  endtask

  task automatic test_single();
    rand_ops();
    opa[2] = 8'd5;
    opb[2] = 8'd3;
    pack_ops();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single req_ready got=%b exp=0100", req_ready); end
    exp_ptr = 3;
    step();
    req_valid = '0;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single mul_start got=%b exp=1", mul_start); end
    checks++; if ({mul_a, mul_b} !== {8'd5, 8'd3}) begin errors++; $display("FAIL single mul_ab got=%h exp=0503", {mul_a, mul_b}); end
    for (int c = 2; c <= 10; c++) begin
      step();
      checks++; if ({resp_valid, mul_start} !== 2'b00) begin errors++; $display("FAIL single early_pulse cycle=%0d got=%b exp=00", c, {resp_valid, mul_start}); end
    end
    step();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single resp_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_id !== 3'd2) begin errors++; $display("FAIL single resp_id got=%0d exp=2", resp_id); end
    checks++; if (resp_product !== 16'h000F) begin errors++; $display("FAIL single resp_product got=%h exp=000f", resp_product); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single resp_err got=%b exp=0", resp_err); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single resp_pulse_width got=%b exp=0", resp_valid); end
    checks++; if (resp_product !== 16'h000F) begin errors++; $display("FAIL single product_hold got=%h exp=000f", resp_product); end
  endtask

  task automatic test_contention();
    int w;
    logic [15:0] exp_p;
    rand_ops();
    opa[1] = 8'hFF;
    opb[1] = 8'hFF;
    pack_ops();
    req_valid = '1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ptr = 0;
    for (int g = 0; g < 5; g++) begin
      #1;
      w = ref_winner(req_valid, exp_ptr);
      checks++; if (req_ready !== onehot(w) || w != (g % N)) begin errors++; $display("FAIL contention grant%0d got=%b exp=%b", g, req_ready, onehot(g % N)); end
      exp_ptr = (w + 1) % N;
      step();
      checks++; if ({mul_start, mul_a, mul_b} !== {1'b1, opa[w], opb[w]}) begin errors++; $display("FAIL contention issue%0d got=%h exp=%h", g, {mul_start, mul_a, mul_b}, {1'b1, opa[w], opb[w]}); end
      for (int c = 2; c <= 10; c++) begin
        step();
        checks++; if ({resp_valid, req_ready} !== '0) begin errors++; $display("FAIL contention busy%0d cycle=%0d got=%b exp=0", g, c, {resp_valid, req_ready}); end
      end
      step();
      exp_p = 16'(opa[w]) * 16'(opb[w]);
      checks++; if ({resp_valid, resp_err, resp_id} !== {1'b1, 1'b0, 3'(w)}) begin errors++; $display("FAIL contention resp%0d got=%b exp=%b", g, {resp_valid, resp_err, resp_id}, {1'b1, 1'b0, 3'(w)}); end
      checks++; if (resp_product !== exp_p) begin errors++; $display("FAIL contention product%0d got=%h exp=%h", g, resp_product, exp_p); end
      step();
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_fairness();
    logic [N-1:0] masks [3];
    int           expw  [3];
    int           w;
    logic [15:0]  exp_p;
    masks[0] = 4'b0010; masks[1] = 4'b1001; masks[2] = 4'b0001;
    expw[0] = 1; expw[1] = 3; expw[2] = 0;
    rand_ops();
    for (int k = 0; k < 3; k++) begin
      req_valid = masks[k];
      #1;
      w = ref_winner(req_valid, exp_ptr);
      checks++; if (req_ready !== onehot(expw[k]) || w != expw[k]) begin errors++; $display("FAIL fairness grant%0d got=%b exp=%b", k, req_ready, onehot(expw[k])); end
      exp_ptr = (w + 1) % N;
      step();
      req_valid = masks[k] & ~onehot(w);
      for (int c = 2; c <= 11; c++) step();
      exp_p = 16'(opa[w]) * 16'(opb[w]);
      checks++; if ({resp_valid, resp_id, resp_product} !== {1'b1, 3'(w), exp_p}) begin errors++; $display("FAIL fairness resp%0d got=%h exp=%h", k, {resp_valid, resp_id, resp_product}, {1'b1, 3'(w), exp_p}); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int r;
    int q;
    logic [15:0] exp_p;
    rand_ops();
    hold_ready = 1'b1;
    r = $urandom_range(0, N - 1);
    req_valid = onehot(r);
    #1;
    checks++; if (req_ready !== onehot(r)) begin errors++; $display("FAIL timeout grant got=%b exp=%b", req_ready, onehot(r)); end
    exp_ptr = (r + 1) % N;
    step();
    req_valid = '0;
    for (int c = 2; c <= 17; c++) begin
      step();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL timeout early_resp cycle=%0d got=1 exp=0", c); end
    end
    step();
    checks++; if ({resp_valid, resp_err, resp_id} !== {1'b1, 1'b1, 3'(r)}) begin errors++; $display("FAIL timeout resp got=%b exp=%b", {resp_valid, resp_err, resp_id}, {1'b1, 1'b1, 3'(r)}); end
    checks++; if (resp_product !== 16'd0) begin errors++; $display("FAIL timeout product got=%h exp=0", resp_product); end
    hold_ready = 1'b0;
    q = $urandom_range(0, N - 1);
    req_valid = onehot(q);
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL timeout ready_in_resp got=%b exp=0", req_ready); end
    step();
    #1;
    checks++; if (req_ready !== onehot(q)) begin errors++; $display("FAIL timeout idle_at_19 got=%b exp=%b", req_ready, onehot(q)); end
    exp_ptr = (q + 1) % N;
    step();
    req_valid = '0;
    for (int c = 2; c <= 11; c++) step();
    exp_p = 16'(opa[q]) * 16'(opb[q]);
    checks++; if ({resp_valid, resp_err, resp_product} !== {1'b1, 1'b0, exp_p}) begin errors++; $display("FAIL timeout recover got=%h exp=%h", {resp_valid, resp_err, resp_product}, {1'b1, 1'b0, exp_p}); end
    step();
  endtask

  task automatic test_race();
    int w;
    logic [15:0] exp_p;
    for (int t = 0; t < 2; t++) begin
      lat = (t == 0) ? 15 : 16;
      rand_ops();
      req_valid = '1;
      #1;
      w = ref_winner(req_valid, exp_ptr);
      exp_ptr = (w + 1) % N;
      step();
      req_valid = '0;
      for (int c = 2; c <= 17; c++) step();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL race%0d early_resp got=1 exp=0", t); end
      step();
      exp_p = (t == 0) ? 16'(opa[w]) * 16'(opb[w]) : 16'd0;
      checks++; if ({resp_valid, resp_err} !== {1'b1, (t == 1)}) begin errors++; $display("FAIL race%0d resp_err got=%b exp=%b", t, {resp_valid, resp_err}, {1'b1, (t == 1)}); end
      checks++; if (resp_product !== exp_p) begin errors++; $display("FAIL race%0d product got=%h exp=%h", t, resp_product, exp_p); end
      step();
    end
    lat = 8;
  endtask

  task automatic test_mid_reset();
    int r;
    rand_ops();
    r = $urandom_range(0, N - 1);
    req_valid = onehot(r);
    step();
    req_valid = '0;
    for (int c = 2; c <= 5; c++) step();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, resp_valid, resp_err, mul_start} !== '0) begin errors++; $display("FAIL midreset ctrl got=%b exp=0", {req_ready, resp_valid, resp_err, mul_start}); end
    checks++; if ({resp_id, resp_product, mul_a, mul_b} !== '0) begin errors++; $display("FAIL midreset data got=%h exp=0", {resp_id, resp_product, mul_a, mul_b}); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midreset resp_in_reset got=1 exp=0"); end
    end
    req_valid = '0;
    rst_n = 1'b1;
    exp_ptr = 0;
    r = $urandom_range(0, N - 1);
    opa[r] = 8'd2;
    opb[r] = 8'd7;
    pack_ops();
    req_valid = onehot(r);
    #1;
    checks++; if (req_ready !== onehot(r)) begin errors++; $display("FAIL midreset grant got=%b exp=%b", req_ready, onehot(r)); end
    exp_ptr = (r + 1) % N;
    step();
    req_valid = '0;
    for (int c = 2; c <= 10; c++) begin
      step();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midreset stale_resp cycle=%0d got=1 exp=0", c); end
    end
    step();
    checks++; if ({resp_valid, resp_id, resp_product} !== {1'b1, 3'(r), 16'h000E}) begin errors++; $display("FAIL midreset resp got=%h exp=%h", {resp_valid, resp_id, resp_product}, {1'b1, 3'(r), 16'h000E}); end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int w;
    logic [15:0] exp_p;
    for (int it = 0; it < 24; it++) begin
      rand_ops();
      mask = N'($urandom_range(0, (1 << N) - 1));
      req_valid = mask;
      #1;
      w = ref_winner(mask, exp_ptr);
      checks++; if (req_ready !== onehot(w)) begin errors++; $display("FAIL random grant%0d got=%b exp=%b", it, req_ready, onehot(w)); end
      if (w < 0) begin
        step();
        continue;
      end
      exp_ptr = (w + 1) % N;
      step();
      req_valid = '0;
      checks++; if ({mul_start, mul_a, mul_b} !== {1'b1, opa[w], opb[w]}) begin errors++; $display("FAIL random issue%0d got=%h exp=%h", it, {mul_start, mul_a, mul_b}, {1'b1, opa[w], opb[w]}); end
      for (int c = 2; c <= 11; c++) step();
      exp_p = 16'(opa[w]) * 16'(opb[w]);
      checks++; if ({resp_valid, resp_err, resp_id, resp_product} !== {1'b1, 1'b0, 3'(w), exp_p}) begin errors++; $display("FAIL random resp%0d got=%h exp=%h", it, {resp_valid, resp_err, resp_id, resp_product}, {1'b1, 1'b0, 3'(w), exp_p}); end
      step();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_race();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
